ren_chain_arbiter: RTL and testbench

// - Round-robin arbiter sharing one read-enable (ren) port among NUM_REQ requesters.
// - Sits between requester components and the downstream ren/ack port.
// - Owns sequencing: one read in flight at a time; grant held until the downstream ack.
// - Returns a one-hot completion pulse to the winning requester.

---
 rtl/ren_chain_arbiter.sv | 141 ++++++++++++++
 tb/tb_ren_chain_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ren_chain_arbiter.sv
// Round-robin arbiter sharing one downstream read-enable port among NUM_REQ requesters.
// Optional WAIT-state timeout abort is enabled by defining REN_ARB_TIMEOUT_EN.
module ren_chain_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_req_ren,
    input  logic [NUM_REQ*ADDR_W-1:0] io_req_addr,
    output logic [NUM_REQ-1:0]        io_gnt,
    output logic                      io_port_ren,
    output logic [ADDR_W-1:0]         io_port_addr,
    input  logic                      io_port_ready,
    input  logic                      io_port_ack,
    output logic [NUM_REQ-1:0]        io_done,
    output logic                      io_busy,
    output logic                      io_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ren_chain_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_next;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand_idx;
    int                 cand;
    logic [ADDR_W-1:0]  req_addr_arr [NUM_REQ];

`ifdef REN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_addr_arr[k] = io_req_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!pick_vld && io_req_ren[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign win_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_idx      <= '0;
            io_gnt       <= '0;
            io_port_ren  <= 1'b0;
            io_port_addr <= '0;
            io_done      <= '0;
            io_busy      <= 1'b0;
            io_err       <= 1'b0;
`ifdef REN_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            io_done <= '0;
            io_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win_idx      <= pick_idx;
                        io_gnt       <= NUM_REQ'(1) << pick_idx;
                        io_port_addr <= req_addr_arr[pick_idx];
                        io_port_ren  <= 1'b1;
                        io_busy      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A same-cycle ack is not consumed here; WAIT needs its own ack.
                    if (io_port_ready) begin
                        io_port_ren <= 1'b0;
                        state       <= WAIT;
`ifdef REN_ARB_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (io_port_ack) begin
                        io_done <= io_gnt;
                        rr_ptr  <= win_next;
                        io_gnt  <= '0;
                        io_busy <= 1'b0;
                        state   <= IDLE;
                    end
`ifdef REN_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        io_err  <= 1'b1;
                        rr_ptr  <= win_next;
                        io_gnt  <= '0;
                        io_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    io_gnt      <= '0;
                    io_port_ren <= 1'b0;
                    io_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ren_chain_arbiter.sv
// Testbench for ren_chain_arbiter: directed and randomized transactions checked against
// a transaction-level round-robin model (timeout section active with REN_ARB_TIMEOUT_EN).
module tb_ren_chain_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic            port_ren;
    logic [AW-1:0]   port_addr;
    logic            ready;
    logic            ack;
    logic [N-1:0]    done;
    logic            busy;
    logic            err;

    int            checks = 0;
    int            errors = 0;
    int            m_ptr  = 0;
    logic [AW-1:0] a [N];

    ren_chain_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_req_ren    (req),
        .io_req_addr   (req_addr),
        .io_gnt        (gnt),
        .io_port_ren   (port_ren),
        .io_port_addr  (port_addr),
        .io_port_ready (ready),
        .io_port_ack   (ack),
        .io_done       (done),
        .io_busy       (busy),
        .io_err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_addr();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = a[i];
    endtask

    // Round-robin rule: first requesting index at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Requests are already driven in the current IDLE cycle; runs one full read.
    task automatic do_txn(input int rdel, input int adel, input bit drop_ok);
        int w;
        logic [31:0] g;
        w = model_pick(req, m_ptr);
        g = 32'(1) << w;
        step();
        chk("issue_gnt", 32'(gnt), g);
        chk("issue_ren", 32'(port_ren), 1);
        chk("issue_addr", 32'(port_addr), 32'(a[w]));
        chk("issue_busy", 32'(busy), 1);
        chk("issue_done", 32'(done), 0);
        for (int i = 0; i < rdel; i++) begin
            ready = 1'b0;
            ack   = 1'($urandom % 2);
            step();
            chk("stall_ren", 32'(port_ren), 1);
            chk("stall_gnt", 32'(gnt), g);
        end
        ready = 1'b1;
        ack   = 1'($urandom % 2);
        if (drop_ok && ($urandom % 3 == 0)) req[w] = 1'b0;
        step();
        ready = 1'b0;
        chk("wait_ren", 32'(port_ren), 0);
        chk("wait_gnt", 32'(gnt), g);
        chk("wait_done", 32'(done), 0);
        chk("wait_busy", 32'(busy), 1);
        for (int j = 0; j < adel; j++) begin
            ack = 1'b0;
            step();
            chk("wait2_gnt", 32'(gnt), g);
            chk("wait2_done", 32'(done), 0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("done_pulse", 32'(done), g);
        chk("done_gnt", 32'(gnt), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_err", 32'(err), 0);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        ready = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < N; i++) a[i] = '0;
        set_addr();
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ren", 32'(port_ren), 0);
        chk("rst_addr", 32'(port_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_ren", 32'(port_ren), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Single requester 2 with address 0x5A.
        a[2] = 8'h5A;
        set_addr();
        req = 4'b0100;
        do_txn(0, 0, 1'b0);
        chk("ptr_after_2", 32'(m_ptr), 3);
        req = '0;
        step();
        chk("idle_after_2", 32'(busy), 0);

        // All requesting from pointer 0: order 0,1,2,3,0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) a[i] = 8'h10 + 8'(i);
        set_addr();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(model_pick(req, m_ptr)), 32'(i % N));
            do_txn(0, 0, 1'b0);
        end

        // Ready held low for 5 cycles.
        do_txn(5, 2, 1'b0);

        // Reset in WAIT: no done, later ack ignored, pointer back to 0.
        req = 4'b0100;
        step();
        chk("rw_gnt", 32'(gnt), 32'b0100);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("rw_wait_ren", 32'(port_ren), 0);
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        chk("rw_gnt0", 32'(gnt), 0);
        chk("rw_busy0", 32'(busy), 0);
        chk("rw_done0", 32'(done), 0);
        m_ptr = 0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rw_ack_done", 32'(done), 0);
        chk("rw_ack_busy", 32'(busy), 0);
        step();
        chk("rw_ack_done2", 32'(done), 0);
        req = 4'b1111;
        do_txn(0, 0, 1'b0);

        // Randomized traffic with request drops and stray acks.
        for (int t = 0; t < 40; t++) begin
            req = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) a[i] = 8'($urandom);
            set_addr();
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

`ifdef REN_ARB_TIMEOUT_EN
        begin
            int w;
            int n;
            req = 4'b1111;
            w = model_pick(req, m_ptr);
            step();
            chk("to_gnt", 32'(gnt), 32'(1) << w);
            ready = 1'b1;
            step();
            ready = 1'b0;
            n = 0;
            while (err !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk("to_cycles", 32'(n), 32'(TO + 1));
            chk("to_done", 32'(done), 0);
            chk("to_gnt0", 32'(gnt), 0);
            chk("to_busy", 32'(busy), 0);
            m_ptr = (w + 1) % N;
            step();
            chk("to_err_pulse", 32'(err), 0);
            req = 4'b1111;
            do_txn(0, 0, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
